// File: rtl/axi_sram_slave.sv
// axi_sram_slave: AXI4 slave in front of a single-ported 64-bit SRAM.
// One transaction in flight at a time; INCR and FIXED bursts of 8-byte beats,
// up to 256 beats. Unsupported size/burst encodings answer SLVERR but still
// run every beat so the master never hangs.

module axi_sram_slave #(
  parameter int AXI_DATA_WIDTH = 64,
  parameter int AXI_ADDR_WIDTH = 64,
  parameter int AXI_ID_WIDTH   = 4,
  parameter int MEM_WORDS_LOG2 = 12
) (
  input  logic                        clk,
  input  logic                        rst,

  output logic                        axi_aw_ready,
  input  logic                        axi_aw_valid,
  input  logic [AXI_ADDR_WIDTH-1:0]   axi_aw_addr,
  input  logic [AXI_ID_WIDTH-1:0]     axi_aw_id,
  input  logic [7:0]                  axi_aw_len,
  input  logic [2:0]                  axi_aw_size,
  input  logic [1:0]                  axi_aw_burst,

  output logic                        axi_w_ready,
  input  logic                        axi_w_valid,
  input  logic [AXI_DATA_WIDTH-1:0]   axi_w_data,
  input  logic [AXI_DATA_WIDTH/8-1:0] axi_w_strb,
  input  logic                        axi_w_last,

  input  logic                        axi_b_ready,
  output logic                        axi_b_valid,
  output logic [1:0]                  axi_b_resp,
  output logic [AXI_ID_WIDTH-1:0]     axi_b_id,

  output logic                        axi_ar_ready,
  input  logic                        axi_ar_valid,
  input  logic [AXI_ADDR_WIDTH-1:0]   axi_ar_addr,
  input  logic [AXI_ID_WIDTH-1:0]     axi_ar_id,
  input  logic [7:0]                  axi_ar_len,
  input  logic [2:0]                  axi_ar_size,
  input  logic [1:0]                  axi_ar_burst,

  input  logic                        axi_r_ready,
  output logic                        axi_r_valid,
  output logic [AXI_DATA_WIDTH-1:0]   axi_r_data,
  output logic [1:0]                  axi_r_resp,
  output logic                        axi_r_last,
  output logic [AXI_ID_WIDTH-1:0]     axi_r_id
);

  localparam int STRB_W = AXI_DATA_WIDTH / 8;
  localparam int DEPTH  = 1 << MEM_WORDS_LOG2;
  localparam int IDX_LO = 3;
  localparam int IDX_HI = MEM_WORDS_LOG2 + 2;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {
    IDLE,
    W_DATA,
    W_RESP,
    R_DATA
  } state_t;

  state_t state;
  state_t state_next;

  logic [AXI_DATA_WIDTH-1:0] mem [DEPTH];

  // Context of the transaction currently in flight
  logic [MEM_WORDS_LOG2-1:0] idx;
  logic [7:0]                beat;
  logic [7:0]                len;
  logic [AXI_ID_WIDTH-1:0]   id;
  logic                      fixed;
  logic                      cfg_err;
  logic                      wlast_err;

  logic                      aw_hs;
  logic                      ar_hs;
  logic                      w_hs;
  logic                      b_hs;
  logic                      r_hs;
  logic                      last_beat;
  logic                      wlast_bad;
  logic                      aw_cfg_err;
  logic                      ar_cfg_err;
  logic [MEM_WORDS_LOG2-1:0] aw_idx;
  logic [MEM_WORDS_LOG2-1:0] ar_idx;
  logic [MEM_WORDS_LOG2-1:0] idx_step;
  logic [MEM_WORDS_LOG2-1:0] rd_idx;
  logic                      rd_en;
  logic                      rd_zero;
  logic                      wr_en;
  logic                      unused_addr_bits;

  assign aw_idx = axi_aw_addr[IDX_HI:IDX_LO];
  assign ar_idx = axi_ar_addr[IDX_HI:IDX_LO];

  // Address bits outside the word index alias onto the same SRAM; no decode error.
  assign unused_addr_bits = ^{axi_aw_addr[AXI_ADDR_WIDTH-1:IDX_HI+1], axi_aw_addr[IDX_LO-1:0],
                              axi_ar_addr[AXI_ADDR_WIDTH-1:IDX_HI+1], axi_ar_addr[IDX_LO-1:0]};

  // Only 8-byte beats are supported; WRAP and the reserved burst encoding are rejected.
  assign aw_cfg_err = (axi_aw_size != 3'd3) || axi_aw_burst[1];
  assign ar_cfg_err = (axi_ar_size != 3'd3) || axi_ar_burst[1];

  // Handshakes are decoded from state and inputs directly so no path loops through the ready outputs.
  // A write request takes priority over a simultaneous read request.
  assign aw_hs = !rst && (state == IDLE) && axi_aw_valid;
  assign ar_hs = !rst && (state == IDLE) && !axi_aw_valid && axi_ar_valid;
  assign w_hs  = !rst && (state == W_DATA) && axi_w_valid;
  assign b_hs  = !rst && (state == W_RESP) && axi_b_ready;
  assign r_hs  = !rst && (state == R_DATA) && axi_r_ready;

  assign last_beat = (beat == len);
  assign wlast_bad = (axi_w_last != last_beat);
  assign idx_step  = fixed ? idx : idx + MEM_WORDS_LOG2'(1);

  // The SRAM has one port: it is read on AR acceptance and on each non-final R handshake,
  // and written on accepted W beats, which can never coincide.
  assign rd_en   = ar_hs || (r_hs && !last_beat);
  assign rd_idx  = ar_hs ? ar_idx : idx_step;
  assign rd_zero = ar_hs ? ar_cfg_err : cfg_err;
  assign wr_en   = w_hs && !cfg_err;

  assign axi_b_id = id;
  assign axi_r_id = id;

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state and handshake outputs; everything reads 0 while reset is held
  always_comb begin
    state_next   = state;
    axi_aw_ready = 1'b0;
    axi_ar_ready = 1'b0;
    axi_w_ready  = 1'b0;
    axi_b_valid  = 1'b0;
    axi_b_resp   = RESP_OKAY;
    axi_r_valid  = 1'b0;
    axi_r_resp   = RESP_OKAY;
    axi_r_last   = 1'b0;
    if (!rst) begin
      case (state)
        IDLE: begin
          axi_aw_ready = 1'b1;
          axi_ar_ready = !axi_aw_valid;
          if (aw_hs) begin
            state_next = W_DATA;
          end else if (ar_hs) begin
            state_next = R_DATA;
          end
        end
        W_DATA: begin
          axi_w_ready = 1'b1;
          if (w_hs && last_beat) begin
            state_next = W_RESP;
          end
        end
        W_RESP: begin
          axi_b_valid = 1'b1;
          axi_b_resp  = (cfg_err || wlast_err) ? RESP_SLVERR : RESP_OKAY;
          if (b_hs) begin
            state_next = IDLE;
          end
        end
        R_DATA: begin
          axi_r_valid = 1'b1;
          axi_r_resp  = cfg_err ? RESP_SLVERR : RESP_OKAY;
          axi_r_last  = last_beat;
          if (r_hs && last_beat) begin
            state_next = IDLE;
          end
        end
        default: state_next = IDLE;
      endcase
    end
  end

  // Latch the request on acceptance, then step the beat counter and word index per beat
  always_ff @(posedge clk) begin
    if (rst) begin
      idx       <= '0;
      beat      <= '0;
      len       <= '0;
      id        <= '0;
      fixed     <= 1'b0;
      cfg_err   <= 1'b0;
      wlast_err <= 1'b0;
    end else if (aw_hs) begin
      idx       <= aw_idx;
      beat      <= '0;
      len       <= axi_aw_len;
      id        <= axi_aw_id;
      fixed     <= (axi_aw_burst == 2'b00);
      cfg_err   <= aw_cfg_err;
      wlast_err <= 1'b0;
    end else if (ar_hs) begin
      idx       <= ar_idx;
      beat      <= '0;
      len       <= axi_ar_len;
      id        <= axi_ar_id;
      fixed     <= (axi_ar_burst == 2'b00);
      cfg_err   <= ar_cfg_err;
      wlast_err <= 1'b0;
    end else if (w_hs) begin
      idx  <= idx_step;
      beat <= beat + 8'd1;
      if (wlast_bad) begin
        wlast_err <= 1'b1;
      end
    end else if (r_hs) begin
      idx  <= idx_step;
      beat <= beat + 8'd1;
    end
  end

  // Registered read port; errored read bursts return zero data
  always_ff @(posedge clk) begin
    if (rst) begin
      axi_r_data <= '0;
    end else if (rd_en) begin
      axi_r_data <= rd_zero ? '0 : mem[rd_idx];
    end
  end

  // Byte-masked write port; contents survive reset
  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int i = 0; i < STRB_W; i++) begin
        if (axi_w_strb[i]) begin
          mem[idx][8*i +: 8] <= axi_w_data[8*i +: 8];
        end
      end
    end
  end

endmodule

// File: tb/tb_axi_sram_slave.sv
// Testbench for axi_sram_slave: a bench-side memory model feeds queues of
// expected R beats and B responses that a negedge monitor compares.
`timescale 1ns/1ps

module tb_axi_sram_slave;

  localparam int IDW   = 4;
  localparam int DEPTH = 4096;

  logic        clk = 1'b0;
  logic        rst;

  logic        axi_aw_ready, axi_aw_valid;
  logic [63:0] axi_aw_addr;
  logic [3:0]  axi_aw_id;
  logic [7:0]  axi_aw_len;
  logic [2:0]  axi_aw_size;
  logic [1:0]  axi_aw_burst;
  logic        axi_w_ready, axi_w_valid;
  logic [63:0] axi_w_data;
  logic [7:0]  axi_w_strb;
  logic        axi_w_last;
  logic        axi_b_ready, axi_b_valid;
  logic [1:0]  axi_b_resp;
  logic [3:0]  axi_b_id;
  logic        axi_ar_ready, axi_ar_valid;
  logic [63:0] axi_ar_addr;
  logic [3:0]  axi_ar_id;
  logic [7:0]  axi_ar_len;
  logic [2:0]  axi_ar_size;
  logic [1:0]  axi_ar_burst;
  logic        axi_r_ready, axi_r_valid;
  logic [63:0] axi_r_data;
  logic [1:0]  axi_r_resp;
  logic        axi_r_last;
  logic [3:0]  axi_r_id;

  always #5 clk = ~clk;

  axi_sram_slave #(
    .AXI_DATA_WIDTH(64),
    .AXI_ADDR_WIDTH(64),
    .AXI_ID_WIDTH(IDW),
    .MEM_WORDS_LOG2(12)
  ) dut (
    .clk(clk), .rst(rst),
    .axi_aw_ready(axi_aw_ready), .axi_aw_valid(axi_aw_valid), .axi_aw_addr(axi_aw_addr),
    .axi_aw_id(axi_aw_id), .axi_aw_len(axi_aw_len), .axi_aw_size(axi_aw_size),
    .axi_aw_burst(axi_aw_burst),
    .axi_w_ready(axi_w_ready), .axi_w_valid(axi_w_valid), .axi_w_data(axi_w_data),
    .axi_w_strb(axi_w_strb), .axi_w_last(axi_w_last),
    .axi_b_ready(axi_b_ready), .axi_b_valid(axi_b_valid), .axi_b_resp(axi_b_resp),
    .axi_b_id(axi_b_id),
    .axi_ar_ready(axi_ar_ready), .axi_ar_valid(axi_ar_valid), .axi_ar_addr(axi_ar_addr),
    .axi_ar_id(axi_ar_id), .axi_ar_len(axi_ar_len), .axi_ar_size(axi_ar_size),
    .axi_ar_burst(axi_ar_burst),
    .axi_r_ready(axi_r_ready), .axi_r_valid(axi_r_valid), .axi_r_data(axi_r_data),
    .axi_r_resp(axi_r_resp), .axi_r_last(axi_r_last), .axi_r_id(axi_r_id)
  );

  typedef struct packed {
    logic [63:0] data;
    logic [1:0]  resp;
    logic        last;
    logic [3:0]  id;
  } r_exp_t;

  typedef struct packed {
    logic [1:0] resp;
    logic [3:0] id;
  } b_exp_t;

  r_exp_t      r_q[$];
  b_exp_t      b_q[$];
  logic [63:0] model [DEPTH];
  int          tests = 0;
  int          failed = 0;
  int          rready_mode = 0;

  task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
    tests++;
    if (actual !== expected) begin
      failed++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
    end
  endtask

  // r_ready: 0 = always ready, 1 = repeating 1,0,0,1 pattern, other = never ready
  initial begin
    int phase;
    phase = 0;
    axi_r_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (rready_mode)
        0: axi_r_ready = 1'b1;
        1: begin
          axi_r_ready = ((phase % 4) == 0) || ((phase % 4) == 3);
          phase++;
        end
        default: axi_r_ready = 1'b0;
      endcase
    end
  end

  // Scoreboard monitor: R data is checked every valid cycle (so stalls must hold it), popped on handshake
  always @(negedge clk) begin
    if (!rst) begin
      if (axi_r_valid) begin
        if (r_q.size() == 0) begin
          checkOutput("r_unexpected", 64'(axi_r_valid), 64'd0);
        end else begin
          checkOutput("r_data", axi_r_data, r_q[0].data);
          checkOutput("r_resp", 64'(axi_r_resp), 64'(r_q[0].resp));
          checkOutput("r_last", 64'(axi_r_last), 64'(r_q[0].last));
          checkOutput("r_id", 64'(axi_r_id), 64'(r_q[0].id));
          if (axi_r_ready) void'(r_q.pop_front());
        end
      end
      if (axi_b_valid && axi_b_ready) begin
        if (b_q.size() == 0) begin
          checkOutput("b_unexpected", 64'(axi_b_valid), 64'd0);
        end else begin
          checkOutput("b_resp", 64'(axi_b_resp), 64'(b_q[0].resp));
          checkOutput("b_id", 64'(axi_b_id), 64'(b_q[0].id));
          void'(b_q.pop_front());
        end
      end
    end
  end

  // Write burst: data beat b = data0 + b*step; w_last is driven on beat last_at (-1: never)
  task automatic writeBurst(input logic [63:0] addr, input logic [3:0] id, input logic [7:0] len,
                            input logic [2:0] size, input logic [1:0] burst, input logic [63:0] data0,
                            input logic [63:0] step, input logic [7:0] strb, input int last_at);
    logic        cfg_err;
    logic [11:0] i0;
    logic [11:0] wi;
    logic [63:0] d;
    logic        hs;
    int          guard;
    b_exp_t      be;
    cfg_err = (size != 3'd3) || burst[1];
    be.resp = (cfg_err || (last_at != int'(len))) ? 2'b10 : 2'b00;
    be.id   = id;
    b_q.push_back(be);
    i0 = addr[14:3];
    for (int b = 0; b <= int'(len); b++) begin
      wi = (burst == 2'b00) ? i0 : i0 + 12'(b);
      d  = data0 + step * 64'(b);
      if (!cfg_err) begin
        for (int k = 0; k < 8; k++) begin
          if (strb[k]) model[wi][8*k +: 8] = d[8*k +: 8];
        end
      end
    end
    axi_aw_addr  = addr;
    axi_aw_id    = id;
    axi_aw_len   = len;
    axi_aw_size  = size;
    axi_aw_burst = burst;
    axi_aw_valid = 1'b1;
    hs = 1'b0;
    guard = 0;
    while (!hs && guard < 50) begin
      @(negedge clk);
      hs = axi_aw_ready;
      @(posedge clk);
      #1;
      guard++;
    end
    axi_aw_valid = 1'b0;
    checkOutput("aw_handshake", 64'(hs), 64'd1);
    for (int b = 0; b <= int'(len); b++) begin
      axi_w_data  = data0 + step * 64'(b);
      axi_w_strb  = strb;
      axi_w_last  = (b == last_at);
      axi_w_valid = 1'b1;
      hs = 1'b0;
      guard = 0;
      while (!hs && guard < 50) begin
        @(negedge clk);
        hs = axi_w_ready;
        @(posedge clk);
        #1;
        guard++;
      end
      checkOutput("w_handshake", 64'(hs), 64'd1);
    end
    axi_w_valid = 1'b0;
    axi_w_last  = 1'b0;
    checkOutput("b_latency", 64'(axi_b_valid), 64'd1);
  endtask

  task automatic waitB();
    int guard;
    guard = 0;
    while (b_q.size() != 0 && guard < 100) begin
      @(posedge clk);
      #1;
      guard++;
    end
    checkOutput("b_drained", 64'(b_q.size()), 64'd0);
  endtask

  task automatic pushReadExp(input logic [63:0] addr, input logic [3:0] id, input logic [7:0] len,
                             input logic [2:0] size, input logic [1:0] burst);
    logic        cfg_err;
    logic [11:0] ri;
    r_exp_t      re;
    cfg_err = (size != 3'd3) || burst[1];
    for (int b = 0; b <= int'(len); b++) begin
      ri      = (burst == 2'b00) ? addr[14:3] : addr[14:3] + 12'(b);
      re.data = cfg_err ? 64'd0 : model[ri];
      re.resp = cfg_err ? 2'b10 : 2'b00;
      re.last = (b == int'(len));
      re.id   = id;
      r_q.push_back(re);
    end
  endtask

  task automatic driveAr(input logic [63:0] addr, input logic [3:0] id, input logic [7:0] len,
                         input logic [2:0] size, input logic [1:0] burst);
    logic hs;
    int   guard;
    axi_ar_addr  = addr;
    axi_ar_id    = id;
    axi_ar_len   = len;
    axi_ar_size  = size;
    axi_ar_burst = burst;
    axi_ar_valid = 1'b1;
    hs = 1'b0;
    guard = 0;
    while (!hs && guard < 50) begin
      @(negedge clk);
      hs = axi_ar_ready;
      @(posedge clk);
      #1;
      guard++;
    end
    axi_ar_valid = 1'b0;
    checkOutput("ar_handshake", 64'(hs), 64'd1);
    checkOutput("r_latency", 64'(axi_r_valid), 64'd1);
  endtask

  task automatic readBurst(input logic [63:0] addr, input logic [3:0] id, input logic [7:0] len,
                           input logic [2:0] size, input logic [1:0] burst);
    int guard;
    pushReadExp(addr, id, len, size, burst);
    driveAr(addr, id, len, size, burst);
    guard = 0;
    while (r_q.size() != 0 && guard < 1200) begin
      @(posedge clk);
      #1;
      guard++;
    end
    checkOutput("r_drained", 64'(r_q.size()), 64'd0);
    checkOutput("ar_ready_after_r", 64'(axi_ar_ready), 64'd1);
    checkOutput("r_valid_after_r", 64'(axi_r_valid), 64'd0);
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst = 1'b1;
    axi_aw_valid = 1'b0; axi_aw_addr = '0; axi_aw_id = '0; axi_aw_len = '0;
    axi_aw_size = 3'd3; axi_aw_burst = 2'b01;
    axi_w_valid = 1'b0; axi_w_data = '0; axi_w_strb = '0; axi_w_last = 1'b0;
    axi_b_ready = 1'b1;
    axi_ar_valid = 1'b0; axi_ar_addr = '0; axi_ar_id = '0; axi_ar_len = '0;
    axi_ar_size = 3'd3; axi_ar_burst = 2'b01;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    checkOutput("rst_aw_ready", 64'(axi_aw_ready), 64'd0);
    checkOutput("rst_ar_ready", 64'(axi_ar_ready), 64'd0);
    checkOutput("rst_w_ready", 64'(axi_w_ready), 64'd0);
    checkOutput("rst_b_valid", 64'(axi_b_valid), 64'd0);
    checkOutput("rst_r_valid", 64'(axi_r_valid), 64'd0);
    checkOutput("rst_r_last", 64'(axi_r_last), 64'd0);
    checkOutput("rst_r_data", axi_r_data, 64'd0);
    checkOutput("rst_r_resp", 64'(axi_r_resp), 64'd0);
    checkOutput("rst_b_resp", 64'(axi_b_resp), 64'd0);
    checkOutput("rst_r_id", 64'(axi_r_id), 64'd0);
    checkOutput("rst_b_id", 64'(axi_b_id), 64'd0);
    rst = 1'b0;
    @(posedge clk);
    #1;
    checkOutput("idle_aw_ready", 64'(axi_aw_ready), 64'd1);
    checkOutput("idle_ar_ready", 64'(axi_ar_ready), 64'd1);

    // W beats offered before any AW must not be accepted
    axi_w_valid = 1'b1; axi_w_data = 64'h5555; axi_w_strb = 8'hFF; axi_w_last = 1'b1;
    repeat (2) begin
      @(negedge clk);
      checkOutput("w_ready_idle", 64'(axi_w_ready), 64'd0);
    end
    @(posedge clk);
    #1;
    axi_w_valid = 1'b0; axi_w_last = 1'b0;

    // T1 single write and readback
    writeBurst(64'h8000_0010, 4'h1, 8'd0, 3'd3, 2'b01, 64'h1122334455667788, 64'd0, 8'hFF, 0);
    waitB();
    readBurst(64'h8000_0010, 4'h2, 8'd0, 3'd3, 2'b01);

    // T2 preload word i = i, then 8-beat cache-line read
    writeBurst(64'h8000_0040, 4'h3, 8'd7, 3'd3, 2'b01, 64'd8, 64'd1, 8'hFF, 7);
    waitB();
    readBurst(64'h8000_0040, 4'h4, 8'd7, 3'd3, 2'b01);

    // T3 partial strobe merge
    writeBurst(64'h8000_0100, 4'h5, 8'd0, 3'd3, 2'b01, 64'hAAAA_AAAA_AAAA_AAAA, 64'd0, 8'hFF, 0);
    waitB();
    writeBurst(64'h8000_0100, 4'h5, 8'd0, 3'd3, 2'b01, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 8'h0F, 0);
    waitB();
    readBurst(64'h8000_0100, 4'h6, 8'd0, 3'd3, 2'b01);

    // T4 R backpressure, then B held off for 5 cycles
    rready_mode = 1;
    readBurst(64'h8000_0040, 4'h7, 8'd3, 3'd3, 2'b01);
    rready_mode = 0;
    axi_b_ready = 1'b0;
    writeBurst(64'h8000_0200, 4'h7, 8'd1, 3'd3, 2'b01, 64'h0123_4567_89AB_CDEF, 64'h10, 8'hFF, 1);
    repeat (5) begin
      checkOutput("b_hold", 64'(axi_b_valid), 64'd1);
      @(posedge clk);
      #1;
    end
    axi_b_ready = 1'b1;
    waitB();
    readBurst(64'h8000_0200, 4'h8, 8'd1, 3'd3, 2'b01);

    // T5 simultaneous AW and AR: write first, read sees the new data
    axi_ar_addr = 64'h8000_0300; axi_ar_id = 4'h9; axi_ar_len = 8'd0;
    axi_ar_size = 3'd3; axi_ar_burst = 2'b01; axi_ar_valid = 1'b1;
    writeBurst(64'h8000_0300, 4'h8, 8'd0, 3'd3, 2'b01, 64'hDEAD_BEEF_CAFE_F00D, 64'd0, 8'hFF, 0);
    checkOutput("t5_ar_blocked", 64'(axi_ar_ready), 64'd0);
    waitB();
    readBurst(64'h8000_0300, 4'h9, 8'd0, 3'd3, 2'b01);

    // T6 errors: bad size write leaves memory alone; early and missing w_last
    writeBurst(64'h8000_0010, 4'hA, 8'd0, 3'd2, 2'b01, 64'h0BAD_0BAD_0BAD_0BAD, 64'd0, 8'hFF, 0);
    waitB();
    readBurst(64'h8000_0010, 4'hA, 8'd0, 3'd3, 2'b01);
    writeBurst(64'h8000_0400, 4'hB, 8'd3, 3'd3, 2'b01, 64'h100, 64'd1, 8'hFF, 1);
    waitB();
    writeBurst(64'h8000_0480, 4'hB, 8'd1, 3'd3, 2'b01, 64'h200, 64'd1, 8'hFF, -1);
    waitB();
    readBurst(64'h8000_0040, 4'hC, 8'd1, 3'd3, 2'b10);
    readBurst(64'h8000_0040, 4'hD, 8'd0, 3'd2, 2'b01);

    // FIXED bursts stay on one word; INCR wraps past the top of the SRAM; upper bits alias
    writeBurst(64'h8000_0500, 4'hE, 8'd3, 3'd3, 2'b00, 64'h500, 64'd1, 8'hFF, 3);
    waitB();
    readBurst(64'h8000_0500, 4'hE, 8'd1, 3'd3, 2'b00);
    writeBurst(64'h8000_7FF8, 4'h1, 8'd1, 3'd3, 2'b01, 64'h7FF0_0000_0000_0000, 64'd1, 8'hFF, 1);
    waitB();
    readBurst(64'h8000_7FF8, 4'h2, 8'd1, 3'd3, 2'b01);
    readBurst(64'h0000_0000, 4'h3, 8'd0, 3'd3, 2'b01);

    // T6 reset in the middle of a read burst
    pushReadExp(64'h8000_0040, 4'h5, 8'd7, 3'd3, 2'b01);
    driveAr(64'h8000_0040, 4'h5, 8'd7, 3'd3, 2'b01);
    repeat (3) begin
      @(posedge clk);
      #1;
    end
    rst = 1'b1;
    @(posedge clk);
    #1;
    r_q.delete();
    checkOutput("midrst_r_valid", 64'(axi_r_valid), 64'd0);
    checkOutput("midrst_r_last", 64'(axi_r_last), 64'd0);
    checkOutput("midrst_r_data", axi_r_data, 64'd0);
    checkOutput("midrst_ar_ready", 64'(axi_ar_ready), 64'd0);
    rst = 1'b0;
    @(posedge clk);
    #1;
    checkOutput("postrst_ar_ready", 64'(axi_ar_ready), 64'd1);
    readBurst(64'h8000_0040, 4'h6, 8'd7, 3'd3, 2'b01);
    readBurst(64'h8000_0010, 4'h7, 8'd0, 3'd3, 2'b01);

    repeat (2) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
